// File: rtl/kanagawa_hal_fifo_rd_ctrl.sv
// kanagawa_hal_fifo_rd_ctrl
// Read-side controller of an asynchronous FIFO. It takes the already
// synchronized Gray write pointer, derives occupancy against a local binary
// read pointer, drives the RAM read port and presents a one-word output
// register with valid/ready handshake. The Gray read pointer is exported for
// the write-domain synchronizer. A sticky error flag reports pointer
// corruption (multi-bit Gray jumps or impossible occupancy).

module kanagawa_hal_fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [WIDTH-1:0]      mem_rd_data,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic                  empty,
    output logic                  ptr_err
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW = ADDR_WIDTH + 1;

    localparam logic [PW-1:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Standard Gray-to-binary: each binary bit is the XOR of all Gray bits
    // at or above it.
    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wr_bin_conv;
    logic [PW-1:0] wr_bin_q;
    logic [PW-1:0] wr_gray_prev;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] ptr_diff;
    logic          gray_multi_bit;
    logic          occ_overflow;
    logic          dout_valid_next;

    // Decode the incoming write pointer and detect Gray codes that moved by
    // more than one bit since last cycle, which a healthy synchronizer never
    // produces.
    always_comb begin
        wr_bin_conv    = gray_to_bin(wr_ptr_gray_sync);
        ptr_diff       = wr_ptr_gray_sync ^ wr_gray_prev;
        gray_multi_bit = (ptr_diff & (ptr_diff - ONE)) != '0;
    end

    // Occupancy is a plain modular difference, so the pointer wrap needs no
    // special handling; anything above the RAM depth means corrupted pointers.
    always_comb begin
        occupancy    = wr_bin_q - rd_bin;
        empty        = (occupancy == '0);
        occ_overflow = (occupancy > DEPTH);
    end

    // Read the RAM whenever a word is available and the output register is
    // either free or being drained this same cycle.
    always_comb begin
        mem_rd_en       = !empty && (!dout_valid || dout_ready);
        mem_rd_addr     = rd_bin[ADDR_WIDTH-1:0];
        rd_bin_next     = mem_rd_en ? (rd_bin + ONE) : rd_bin;
        dout_valid_next = dout_valid;
        if (mem_rd_en) begin
            dout_valid_next = 1'b1;
        end else if (dout_ready) begin
            dout_valid_next = 1'b0;
        end
    end

    // The RAM holds its output while mem_rd_en is low, so the output word
    // needs no local register of its own.
    always_comb begin
        dout = mem_rd_data;
    end

    // Pointer state and output-valid register; the Gray read pointer is
    // computed from the next binary value so it is itself a clean register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin_q     <= '0;
            wr_gray_prev <= '0;
            rd_bin       <= '0;
            rd_ptr_gray  <= '0;
            dout_valid   <= 1'b0;
        end else begin
            wr_bin_q     <= wr_bin_conv;
            wr_gray_prev <= wr_ptr_gray_sync;
            rd_bin       <= rd_bin_next;
            rd_ptr_gray  <= (rd_bin_next >> 1) ^ rd_bin_next;
            dout_valid   <= dout_valid_next;
        end
    end

    // Sticky pointer error; observational only, it never gates the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_err <= 1'b0;
        end else if (gray_multi_bit || occ_overflow) begin
            ptr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kanagawa_hal_fifo_rd_ctrl.sv
// tb_kanagawa_hal_fifo_rd_ctrl
// Directed bench for the FIFO read controller with ADDR_WIDTH=3, WIDTH=8.
// A small RAM model returns ram[addr] one cycle after mem_rd_en and holds it.

module tb_kanagawa_hal_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] wr_ptr_gray_sync;
    logic [3:0] rd_ptr_gray;
    logic       mem_rd_en;
    logic [2:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [3:0] occupancy;
    logic       empty;
    logic       ptr_err;

    int checks;
    int errors;

    logic [7:0] ram [8];

    kanagawa_hal_fifo_rd_ctrl #(
        .ADDR_WIDTH(3),
        .WIDTH     (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_ptr_gray_sync(wr_ptr_gray_sync),
        .rd_ptr_gray     (rd_ptr_gray),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .occupancy       (occupancy),
        .empty           (empty),
        .ptr_err         (ptr_err)
    );

    // Free-running read clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: synchronous read, output held while not enabled.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= ram[mem_rd_addr];
        end
    end

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        wr_ptr_gray_sync = 4'b0000;
        dout_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_ptr_gray_sync = 4'b0000;
        dout_ready = 1'b0;
        tick();
        tick();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %0b exp 1", empty); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rden got %0b exp 0", mem_rd_en); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", dout_valid); end
        checks++; if (rd_ptr_gray !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rdgray got %b exp 0000", rd_ptr_gray); end
        checks++; if (ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b exp 0", ptr_err); end
        rst_n = 1'b1;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_empty got %0b exp 1", empty); end
    endtask

    task automatic test_first_word();
        reset_dut();
        wr_ptr_gray_sync = 4'b0001;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fw_c0_empty got %0b exp 1", empty); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL fw_c0_rden got %0b exp 0", mem_rd_en); end
        tick();
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL fw_c1_rden got %0b exp 1", mem_rd_en); end
        checks++; if (mem_rd_addr !== 3'd0) begin errors++; $display("[TB] FAIL fw_c1_addr got %0d exp 0", mem_rd_addr); end
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL fw_c1_empty got %0b exp 0", empty); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL fw_c1_valid got %0b exp 0", dout_valid); end
        tick();
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL fw_c2_valid got %0b exp 1", dout_valid); end
        checks++; if (dout !== ram[0]) begin errors++; $display("[TB] FAIL fw_c2_dout got %h exp %h", dout, ram[0]); end
        checks++; if (rd_ptr_gray !== 4'b0001) begin errors++; $display("[TB] FAIL fw_c2_rdgray got %b exp 0001", rd_ptr_gray); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fw_c2_empty got %0b exp 1", empty); end
        dout_ready = 1'b1;
        #1;
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL fw_pop_rden got %0b exp 0", mem_rd_en); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL fw_drop_valid got %0b exp 0", dout_valid); end
        dout_ready = 1'b0;
    endtask

    task automatic test_burst(input int stall);
        logic exp_en;
        reset_dut();
        dout_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wr_ptr_gray_sync = g(4'(i));
            tick();
        end
        checks++; if (occupancy !== 4'd7) begin errors++; $display("[TB] FAIL burst_occ got %0d exp 7", occupancy); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL burst_valid got %0b exp 1", dout_valid); end
        checks++; if (dout !== ram[0]) begin errors++; $display("[TB] FAIL burst_dout0 got %h exp %h", dout, ram[0]); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL burst_hold_rden got %0b exp 0", mem_rd_en); end
        for (int s = 0; s < stall; s++) begin
            tick();
            checks++; if (dout !== ram[0]) begin errors++; $display("[TB] FAIL stall_dout got %h exp %h", dout, ram[0]); end
            checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL stall_rden got %0b exp 0", mem_rd_en); end
            checks++; if (occupancy !== 4'd7) begin errors++; $display("[TB] FAIL stall_occ got %0d exp 7", occupancy); end
        end
        dout_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_en = (k < 7) ? 1'b1 : 1'b0;
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL pop%0d_valid got %0b exp 1", k, dout_valid); end
            checks++; if (dout !== ram[k]) begin errors++; $display("[TB] FAIL pop%0d_dout got %h exp %h", k, dout, ram[k]); end
            checks++; if (mem_rd_en !== exp_en) begin errors++; $display("[TB] FAIL pop%0d_rden got %0b exp %0b", k, mem_rd_en, exp_en); end
            tick();
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL burst_end_valid got %0b exp 0", dout_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL burst_end_empty got %0b exp 1", empty); end
        checks++; if (rd_ptr_gray !== 4'b1100) begin errors++; $display("[TB] FAIL burst_end_rdgray got %b exp 1100", rd_ptr_gray); end
    endtask

    // Continues from the state left by test_burst: rd_bin=8, write pointer 8.
    task automatic test_wrap();
        int         exp_addr [5];
        logic [3:0] exp_gray [5];
        exp_addr = '{5, 6, 7, 0, 1};
        exp_gray = '{4'b1000, 4'b0000, 4'b0001, 4'b0011, 4'b0011};
        dout_ready = 1'b1;
        for (int i = 9; i <= 13; i++) begin
            wr_ptr_gray_sync = g(4'(i));
            tick();
        end
        repeat (4) tick();
        checks++; if (rd_ptr_gray !== 4'b1011) begin errors++; $display("[TB] FAIL wrap_pre_rdgray got %b exp 1011", rd_ptr_gray); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_pre_valid got %0b exp 0", dout_valid); end
        dout_ready = 1'b0;
        wr_ptr_gray_sync = g(4'd14);
        repeat (3) tick();
        wr_ptr_gray_sync = g(4'd15); tick();
        wr_ptr_gray_sync = g(4'd0);  tick();
        wr_ptr_gray_sync = g(4'd1);  tick();
        wr_ptr_gray_sync = g(4'd2);  tick();
        checks++; if (occupancy !== 4'd4) begin errors++; $display("[TB] FAIL wrap_occ got %0d exp 4", occupancy); end
        checks++; if (rd_ptr_gray !== 4'b1001) begin errors++; $display("[TB] FAIL wrap_rdgray14 got %b exp 1001", rd_ptr_gray); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid got %0b exp 1", dout_valid); end
        dout_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++; if (dout !== ram[exp_addr[j]]) begin errors++; $display("[TB] FAIL wrap_pop%0d_dout got %h exp %h", j, dout, ram[exp_addr[j]]); end
            checks++; if (occupancy !== 4'(4 - j)) begin errors++; $display("[TB] FAIL wrap_pop%0d_occ got %0d exp %0d", j, occupancy, 4 - j); end
            tick();
            checks++; if (rd_ptr_gray !== exp_gray[j]) begin errors++; $display("[TB] FAIL wrap_pop%0d_rdgray got %b exp %b", j, rd_ptr_gray, exp_gray[j]); end
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end_valid got %0b exp 0", dout_valid); end
        checks++; if (ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_err got %0b exp 0", ptr_err); end
        dout_ready = 1'b0;
    endtask

    task automatic test_overflow_err();
        reset_dut();
        dout_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            wr_ptr_gray_sync = g(4'(i));
            tick();
            if (i >= 9) begin
                checks++; if (ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL ovf_step%0d_err got %0b exp 0", i, ptr_err); end
            end
        end
        checks++; if (occupancy !== 4'd9) begin errors++; $display("[TB] FAIL ovf_occ got %0d exp 9", occupancy); end
        tick();
        checks++; if (ptr_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err got %0b exp 1", ptr_err); end
    endtask

    task automatic test_gray_err();
        reset_dut();
        tick();
        wr_ptr_gray_sync = 4'b0011;
        #1;
        checks++; if (ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL gerr_before got %0b exp 0", ptr_err); end
        tick();
        checks++; if (ptr_err !== 1'b1) begin errors++; $display("[TB] FAIL gerr_set got %0b exp 1", ptr_err); end
        dout_ready = 1'b1;
        repeat (5) tick();
        checks++; if (ptr_err !== 1'b1) begin errors++; $display("[TB] FAIL gerr_sticky got %0b exp 1", ptr_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (ptr_err !== 1'b0) begin errors++; $display("[TB] FAIL gerr_clear got %0b exp 0", ptr_err); end
        wr_ptr_gray_sync = 4'b0000;
        dout_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_transfer();
        reset_dut();
        dout_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr_ptr_gray_sync = g(4'(i));
            tick();
        end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid got %0b exp 1", dout_valid); end
        checks++; if (occupancy !== 4'd3) begin errors++; $display("[TB] FAIL mid_pre_occ got %0d exp 3", occupancy); end
        rst_n = 1'b0;
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %0b exp 0", dout_valid); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL mid_occ got %0d exp 0", occupancy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_empty got %0b exp 1", empty); end
        checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_rden got %0b exp 0", mem_rd_en); end
        checks++; if (rd_ptr_gray !== 4'b0000) begin errors++; $display("[TB] FAIL mid_rdgray got %b exp 0000", rd_ptr_gray); end
        wr_ptr_gray_sync = 4'b0000;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL mid_rel%0d_empty got %0b exp 1", c, empty); end
        end
        wr_ptr_gray_sync = 4'b0001;
        tick();
        checks++; if (empty !== 1'b0) begin errors++; $display("[TB] FAIL mid_new_empty got %0b exp 0", empty); end
        checks++; if (mem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_new_rden got %0b exp 1", mem_rd_en); end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        mem_rd_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ram[i] = 8'(8'hA0 + 8'(i * 7));
        end
        rst_n = 1'b1;
        wr_ptr_gray_sync = 4'b0000;
        dout_ready = 1'b0;
        test_reset();
        test_first_word();
        test_burst(0);
        test_burst(4);
        test_wrap();
        test_overflow_err();
        test_gray_err();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
